// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 7-seg scanner with hex decode, leading-zero blanking, dead time, frame-synced double buffer; SEG_BLINK_EN adds blink.
// Latency: outputs registered one cycle behind the scan state; no backpressure (load always accepted, last write before the frame wrap wins).
module seg_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 12000,
  parameter int DEAD_CYC = 2,
  parameter int SEG_INV  = 0
`ifdef SEG_BLINK_EN
  , parameter int BLINK_FRAMES = 256
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  lzb,
`ifdef SEG_BLINK_EN
  input  logic [DIGITS-1:0]     blink_mask,
`endif
  output logic                  upd_pending,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig_n,
  output logic                  frame_start
);

  localparam int CNT_MAX = (SCAN_DIV > DEAD_CYC) ? SCAN_DIV : DEAD_CYC;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [7:0]    SEG_OFF   = (SEG_INV != 0) ? 8'hFF : 8'h00;

  typedef enum logic {SHOW, DEAD} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   disp_dat_q, disp_dat_d, shd_dat_q, shd_dat_d;
  logic [DIGITS-1:0]     disp_dp_q, disp_dp_d, shd_dp_q, shd_dp_d;
  logic                  pend_q, pend_d;
  logic [7:0]            seg_q, seg_d, seg_raw;
  logic [DIGITS-1:0]     dig_n_q, dig_n_d;
  logic                  fs_q, fs_d;
  logic                  wrap;
  logic [3:0]            cur_dat;
  logic [DIGITS-1:0]     blank;
  logic                  lead;

`ifdef SEG_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);
  logic [FW-1:0] frm_q, frm_d;
  logic          blink_on_q, blink_on_d;
`endif

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // Zero digits are blanked from the MSD down until the first nonzero one; digit 0 always shows.
  always_comb begin
    lead  = lzb;
    blank = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (disp_dat_q[4*k +: 4] != 4'h0) lead = 1'b0;
      blank[k] = lead;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    disp_dat_d = disp_dat_q;
    disp_dp_d  = disp_dp_q;
    shd_dat_d  = shd_dat_q;
    shd_dp_d   = shd_dp_q;
    pend_d     = pend_q;
    seg_raw    = 8'h00;
    dig_n_d    = '1;
    fs_d       = 1'b0;
    wrap       = 1'b0;
    cur_dat    = disp_dat_q[4*idx_q +: 4];
`ifdef SEG_BLINK_EN
    frm_d      = frm_q;
    blink_on_d = blink_on_q;
`endif
    case (state_q)
      SHOW: begin
        dig_n_d = ~(DIGITS'(1) << idx_q);
        seg_raw = {disp_dp_q[idx_q], blank[idx_q] ? 7'h00 : hex7(cur_dat)};
`ifdef SEG_BLINK_EN
        if (!blink_on_q && blink_mask[idx_q]) seg_raw = 8'h00;
`endif
        fs_d = (idx_q == '0) && (cnt_q == '0);
        if (cnt_q == SCAN_LAST) begin
          cnt_d   = '0;
          wrap    = (idx_q == IDX_LAST);
          idx_d   = wrap ? '0 : idx_q + 1'b1;
          state_d = (DEAD_CYC > 0) ? DEAD : SHOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DEAD: begin
        if (cnt_q == DEAD_LAST) begin
          cnt_d   = '0;
          state_d = SHOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = SHOW;
    endcase
    // Commit takes the pre-edge shadow, so a coincident load lands for the next frame.
    if (wrap) begin
      disp_dat_d = shd_dat_q;
      disp_dp_d  = shd_dp_q;
      pend_d     = 1'b0;
`ifdef SEG_BLINK_EN
      if (frm_q == FRM_LAST) begin
        frm_d      = '0;
        blink_on_d = ~blink_on_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
`endif
    end
    if (load) begin
      shd_dat_d = data_in;
      shd_dp_d  = dp_in;
      pend_d    = 1'b1;
    end
    seg_d = (SEG_INV != 0) ? ~seg_raw : seg_raw;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SHOW;
      cnt_q      <= '0;
      idx_q      <= '0;
      disp_dat_q <= '0;
      disp_dp_q  <= '0;
      shd_dat_q  <= '0;
      shd_dp_q   <= '0;
      pend_q     <= 1'b0;
      seg_q      <= SEG_OFF;
      dig_n_q    <= '1;
      fs_q       <= 1'b0;
`ifdef SEG_BLINK_EN
      frm_q      <= '0;
      blink_on_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_dat_q <= disp_dat_d;
      disp_dp_q  <= disp_dp_d;
      shd_dat_q  <= shd_dat_d;
      shd_dp_q   <= shd_dp_d;
      pend_q     <= pend_d;
      seg_q      <= seg_d;
      dig_n_q    <= dig_n_d;
      fs_q       <= fs_d;
`ifdef SEG_BLINK_EN
      frm_q      <= frm_d;
      blink_on_q <= blink_on_d;
`endif
    end
  end

  assign seg         = seg_q;
  assign dig_n       = dig_n_q;
  assign frame_start = fs_q;
  assign upd_pending = pend_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a timeline model (frame position = cycle count mod frame period) predicts every output each cycle.
// Main instance: 4 digits, SCAN_DIV=4, DEAD_CYC=1; second instance: SEG_INV=1, DEAD_CYC=0.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        lzb = 1'b0;
  logic        upd_pending, frame_start;
  logic [7:0]  seg;
  logic [3:0]  dig_n;

  logic [15:0] data_in2 = '0;
  logic [3:0]  dp_in2 = '0;
  logic        load2 = 1'b0;
  logic        lzb2 = 1'b0;
  logic        upd_pending2, frame_start2;
  logic [7:0]  seg2;
  logic [3:0]  dig_n2;

  int checks = 0;
  int failures = 0;

  // Model state: edges since reset release, committed and shadow contents, pending flag.
  int          n = 0;
  logic [15:0] m_disp = '0, m_shad = '0;
  logic [3:0]  m_dpd = '0, m_dps = '0;
  logic        m_pend = 1'b0;
  logic [6:0]  tbl [16];
  logic [7:0]  cap [4];

  always #5 clk = ~clk;

  seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .DEAD_CYC(1), .SEG_INV(0)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .load(load), .lzb(lzb),
    .upd_pending(upd_pending), .seg(seg), .dig_n(dig_n), .frame_start(frame_start));

  seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .DEAD_CYC(0), .SEG_INV(1)) dut2 (
    .clk(clk), .rst(rst), .data_in(data_in2), .dp_in(dp_in2), .load(load2), .lzb(lzb2),
    .upd_pending(upd_pending2), .seg(seg2), .dig_n(dig_n2), .frame_start(frame_start2));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s at t=%0t: observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int d);
    logic [15:0] hi;
    logic [6:0]  s;
    hi = m_disp >> (4 * d);
    s  = (lzb && d != 0 && hi == 16'h0) ? 7'h00 : tbl[hi[3:0]];
    return {m_dpd[d], s};
  endfunction

  // One clock: frame period 20 = 4 digits x (4 lit + 1 dark); commit on the last lit cycle of digit 3.
  task automatic step(input bit ld, input logic [15:0] d, input logic [3:0] dp);
    int p;
    logic [7:0] es;
    logic [3:0] edn;
    p = n % 20;
    if (p % 5 == 4) begin
      edn = 4'hF;
      es  = 8'h00;
    end else begin
      edn = ~(4'b0001 << (p / 5));
      es  = exp_seg(p / 5);
    end
    if (p == 18) begin
      m_disp = m_shad;
      m_dpd  = m_dps;
      m_pend = 1'b0;
    end
    if (ld) begin
      m_shad = d;
      m_dps  = dp;
      m_pend = 1'b1;
    end
    n++;
    load = ld; data_in = d; dp_in = dp;
    @(posedge clk); #1;
    load = 1'b0;
    chk("dig_n", {12'h0, dig_n}, {12'h0, edn});
    chk("seg", {8'h0, seg}, {8'h0, es});
    chk("frame_start", {15'h0, frame_start}, {15'h0, (p == 0)});
    chk("upd_pending", {15'h0, upd_pending}, {15'h0, m_pend});
  endtask

  task automatic idle_to(input int pos);
    while (n % 20 != pos) step(1'b0, 16'h0, 4'h0);
  endtask

  task automatic run_frame();
    int p;
    idle_to(0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 16'h0, 4'h0);
      p = (n - 1) % 20;
      if (p % 5 == 0) cap[p / 5] = seg;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    #22;
    chk("rst_seg", {8'h0, seg}, 16'h0000);
    chk("rst_dig_n", {12'h0, dig_n}, 16'h000F);
    chk("rst_pend", {15'h0, upd_pending}, 16'h0);
    chk("rst_fs", {15'h0, frame_start}, 16'h0);
    chk("rst_seg_inv", {8'h0, seg2}, 16'h00FF);
    rst = 1'b0;

    // Hex decode with a decimal point.
    step(1'b1, 16'h1A3F, 4'b0100);
    run_frame();
    chk("hex_d0", {8'h0, cap[0]}, 16'h0071);
    chk("hex_d1", {8'h0, cap[1]}, 16'h004F);
    chk("hex_d2", {8'h0, cap[2]}, 16'h00F7);
    chk("hex_d3", {8'h0, cap[3]}, 16'h0006);

    // Leading-zero blanking on, then off.
    lzb = 1'b1;
    step(1'b1, 16'h0050, 4'b0000);
    run_frame();
    chk("lzb_d3", {8'h0, cap[3]}, 16'h0000);
    chk("lzb_d2", {8'h0, cap[2]}, 16'h0000);
    chk("lzb_d1", {8'h0, cap[1]}, 16'h006D);
    chk("lzb_d0", {8'h0, cap[0]}, 16'h003F);
    lzb = 1'b0;
    run_frame();
    chk("nolzb_d3", {8'h0, cap[3]}, 16'h003F);
    chk("nolzb_d2", {8'h0, cap[2]}, 16'h003F);

    // All zero with blanking: blanked MSD keeps its dp, digit 0 never blanks.
    lzb = 1'b1;
    step(1'b1, 16'h0000, 4'b1000);
    run_frame();
    chk("zero_d3", {8'h0, cap[3]}, 16'h0080);
    chk("zero_d2", {8'h0, cap[2]}, 16'h0000);
    chk("zero_d1", {8'h0, cap[1]}, 16'h0000);
    chk("zero_d0", {8'h0, cap[0]}, 16'h003F);
    lzb = 1'b0;

    // Two mid-frame loads: last write wins, nothing tears before the wrap.
    idle_to(0);
    step(1'b0, 16'h0, 4'h0);
    step(1'b0, 16'h0, 4'h0);
    step(1'b1, 16'h1111, 4'h0);
    idle_to(7);
    step(1'b1, 16'h2222, 4'h0);
    run_frame();
    for (int k = 0; k < 4; k++) chk("last_wins", {8'h0, cap[k]}, 16'h005B);

    // Load on the commit cycle stays pending for the next frame.
    idle_to(18);
    step(1'b1, 16'h3333, 4'h0);
    chk("pend_on_wrap", {15'h0, upd_pending}, 16'h1);

    // Asynchronous reset while digit 2 is lit.
    idle_to(11);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_dig_n", {12'h0, dig_n}, 16'h000F);
    chk("mid_rst_seg", {8'h0, seg}, 16'h0000);
    chk("mid_rst_pend", {15'h0, upd_pending}, 16'h0);
    m_disp = '0; m_shad = '0; m_dpd = '0; m_dps = '0; m_pend = 1'b0; n = 0;
    #2 rst = 1'b0;
    step(1'b0, 16'h0, 4'h0);
    chk("restart_fs", {15'h0, frame_start}, 16'h1);

    // Randomized loads, data, dp and blanking level.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) lzb = ~lzb;
      step(($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom));
    end

    // Inverted segments, no dead time.
    data_in2 = 16'h8888;
    load2 = 1'b1;
    @(posedge clk); #1;
    load2 = 1'b0;
    repeat (40) @(posedge clk);
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      chk("inv_seg", {8'h0, seg2}, 16'h0080);
      chk("inv_onehot", 16'($countones(~dig_n2)), 16'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
